// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns: one 32-bit column per clock through a single
// shared GF(2^8) column multiplier, with a per-block bypass for the final round.
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t               r_fsm;
  fsm_t               w_fsm_nxt;
  logic [1:0]         r_col;
  logic [STATE_W-1:0] r_data;
  logic [STATE_W-1:0] w_data_mixed;
  logic [COL_W-1:0]   w_col_in;
  logic [COL_W-1:0]   w_col_out;
  logic [BYTE_W-1:0]  w_a0, w_a1, w_a2, w_a3;
  logic [BYTE_W-1:0]  w_x0, w_x1, w_x2, w_x3;
  logic               w_accept;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
    return {x[BYTE_W-2:0], 1'b0} ^ (x[BYTE_W-1] ? 8'h1B : 8'h00);
  endfunction

  // Column select feeding the shared multiplier
  always_comb begin
    w_col_in = r_data[127:96];
    case (r_col)
      2'd0:    w_col_in = r_data[127:96];
      2'd1:    w_col_in = r_data[95:64];
      2'd2:    w_col_in = r_data[63:32];
      default: w_col_in = r_data[31:0];
    endcase
  end

  assign w_a0 = w_col_in[31:24];
  assign w_a1 = w_col_in[23:16];
  assign w_a2 = w_col_in[15:8];
  assign w_a3 = w_col_in[7:0];

  assign w_x0 = xtime(w_a0);
  assign w_x1 = xtime(w_a1);
  assign w_x2 = xtime(w_a2);
  assign w_x3 = xtime(w_a3);

  // 3a = xtime(a) ^ a
  assign w_col_out = {
    w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3,
    w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3,
    w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3),
    (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3
  };

  always_comb begin
    w_data_mixed = r_data;
    case (r_col)
      2'd0:    w_data_mixed[127:96] = w_col_out;
      2'd1:    w_data_mixed[95:64]  = w_col_out;
      2'd2:    w_data_mixed[63:32]  = w_col_out;
      default: w_data_mixed[31:0]   = w_col_out;
    endcase
  end

  // Next-state and in_ready; in_ready never looks at in_valid
  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_nxt = in_last ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (r_col == 2'd3) w_fsm_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) w_fsm_nxt = in_last ? S_DONE : S_BUSY;
          else          w_fsm_nxt = S_IDLE;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // Load on accept, otherwise rewrite one column per BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_col  <= 2'd0;
    end else if (w_accept) begin
      r_data <= in_data;
      r_col  <= 2'd0;
    end else if (r_fsm == S_BUSY) begin
      r_data <= w_data_mixed;
      r_col  <= r_col + 2'd1;
    end
  end

  assign out_valid = (r_fsm == S_DONE);
  assign out_data  = r_data;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: directed FIPS-197 vectors, bypass,
// backpressure, mid-block reset and a randomised back-to-back stream.
module tb_mix_columns_seq;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] FIPS_IN  = 128'hD4BF5D30E0B452AEB84111F11E2798E5;
  localparam logic [127:0] FIPS_OUT = 128'h046681E5E0CB199A48F8D37A2806264C;
  localparam logic [127:0] KC_IN    = 128'hDB135345F20A225C01010101C6C6C6C6;
  localparam logic [127:0] KC_OUT   = 128'h8E4DA1BC9FDC589D01010101C6C6C6C6;

  mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic last);
    logic [7:0]   coef [4];
    logic [127:0] r;
    logic [7:0]   acc;
    coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
    if (last) return d;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(d[127 - 8*(4*c + k) -: 8], coef[(k - row + 4) % 4]);
        r[127 - 8*(4*c + row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Scoreboard: pop/compare on output handshake, push on input handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_data, 128'hx);
        else                   check("sb_out", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_last));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d, input logic last);
    int g = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    check("send_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  int lat;
  int acc_cnt;
  int guard;
  logic [127:0] blk;
  logic         blk_last;
  logic         will_acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);

    // FIPS-197 round 1 column mix
    out_ready = 1'b1;
    send(FIPS_IN, 1'b0);
    wait_valid(lat);
    check("fips_latency", 128'(lat), 128'd4);
    check("fips_data", out_data, FIPS_OUT);
    tick();

    send(KC_IN, 1'b0);
    wait_valid(lat);
    check("kc_latency", 128'(lat), 128'd4);
    check("kc_data", out_data, KC_OUT);
    tick();

    // Bypass: output the cycle after acceptance
    send(FIPS_IN, 1'b1);
    wait_valid(lat);
    check("byp_latency", 128'(lat), 128'd0);
    check("byp_data", out_data, FIPS_IN);
    tick();
    check("byp_no_dup", 128'(out_valid), 128'd0);

    // Backpressure then back-to-back accept on release
    out_ready = 1'b0;
    send(FIPS_IN, 1'b0);
    wait_valid(lat);
    check("bp_latency", 128'(lat), 128'd4);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", out_data, FIPS_OUT);
      check("bp_valid", 128'(out_valid), 128'd1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      tick();
    end
    in_valid = 1'b1; in_data = KC_IN; in_last = 1'b0; out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("b2b_latency", 128'(lat), 128'd4);
    check("b2b_data", out_data, KC_OUT);
    tick();

    // Reset after column 1 has been written
    send(FIPS_IN, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'd0);
    check("mid_rst_data", out_data, 128'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready", 128'(in_ready), 128'd1);
    send(KC_IN, 1'b0);
    wait_valid(lat);
    check("post_rst_latency", 128'(lat), 128'd4);
    check("post_rst_data", out_data, KC_OUT);
    tick();

    // Random stream, scoreboard does the data checks
    acc_cnt = 0;
    guard   = 0;
    while (acc_cnt < 8 && guard < 2000) begin
      blk      = {$urandom, $urandom, $urandom, $urandom};
      blk_last = 1'($urandom_range(0, 1));
      will_acc = 1'b0;
      while (!will_acc && guard < 2000) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = blk;
        in_last   = blk_last;
        out_ready = 1'($urandom_range(0, 3) != 0);
        #1;
        will_acc = in_valid && in_ready;
        tick();
        guard++;
      end
      if (will_acc) acc_cnt++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_accepted", 128'(acc_cnt), 128'd8);
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
      tick();
      guard++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'd0);
    check("drain_idle", 128'(out_valid), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
